// File: rtl/perceptron_pkg.sv
// Shared definitions for the perceptron training datapath and its sequencer.
package perceptron_pkg;

  localparam int WORD_W = 32;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_LOAD,
    S_EVAL,
    S_UPDATE,
    S_NEXT,
    S_EPOCH_END,
    S_DONE
  } train_state_t;

endpackage

// File: rtl/train_epoch_counter.sv
// Sample index, completed-epoch and per-epoch mismatch counters, with the
// end-of-epoch, epoch-limit and zero-error flags the training FSM branches on.
module train_epoch_counter #(
  parameter int NUM_SAMPLES = 16,
  parameter int ADDR_W      = 4,
  parameter int MAX_EPOCHS  = 255,
  parameter int EPOCH_W     = 8
) (
  input  logic               clk,
  input  logic               rst_ni,
  input  logic               run_clr_i,
  input  logic               idx_inc_i,
  input  logic               err_inc_i,
  input  logic               epoch_end_i,
  output logic [ADDR_W-1:0]  idx_o,
  output logic [EPOCH_W-1:0] epoch_o,
  output logic [ADDR_W:0]    err_o,
  output logic               last_idx_o,
  output logic               limit_o,
  output logic               zero_err_o
);

  localparam int ERR_W = ADDR_W + 1;

  logic [ADDR_W-1:0]  idx_q;
  logic [EPOCH_W-1:0] epoch_q;
  logic [ERR_W-1:0]   err_q;

  assign last_idx_o = (idx_q == ADDR_W'(NUM_SAMPLES - 1));
  // Evaluated before the increment: true when the epoch now ending is the last allowed.
  assign limit_o    = ((epoch_q + EPOCH_W'(1)) == EPOCH_W'(MAX_EPOCHS));
  assign zero_err_o = (err_q == '0);

  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      idx_q   <= '0;
      epoch_q <= '0;
      err_q   <= '0;
    end else if (run_clr_i) begin
      idx_q   <= '0;
      epoch_q <= '0;
      err_q   <= '0;
    end else if (epoch_end_i) begin
      epoch_q <= epoch_q + EPOCH_W'(1);
      // Counters are only rewound when another epoch follows; a finished run keeps them.
      if (!zero_err_o && !limit_o) begin
        idx_q <= '0;
        err_q <= '0;
      end
    end else begin
      if (idx_inc_i) idx_q <= idx_q + ADDR_W'(1);
      if (err_inc_i) err_q <= err_q + ERR_W'(1);
    end
  end

  assign idx_o   = idx_q;
  assign epoch_o = epoch_q;
  assign err_o   = err_q;

endmodule

// File: rtl/perceptron_train_ctrl.sv
// Training sequencer: streams stored samples into the perceptron, strobes a weight
// update on every output mismatch, and repeats epochs until convergence or the limit.
module perceptron_train_ctrl
  import perceptron_pkg::*;
#(
  parameter int N           = 8,
  parameter int NUM_SAMPLES = 16,
  parameter int ADDR_W      = 4,
  parameter int MAX_EPOCHS  = 255,
  parameter int EPOCH_W     = 8,
  parameter int PIPE_LAT    = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               abort,
  input  logic [WORD_W-1:0]  learning_rate_in,
  output logic               mem_rd_en,
  output logic [ADDR_W-1:0]  mem_addr,
  input  logic [N-1:0]       mem_x,
  input  logic [WORD_W-1:0]  mem_expected_y,
  output logic [N-1:0]       p_x,
  output logic [WORD_W-1:0]  p_expected_y,
  output logic [WORD_W-1:0]  p_learning_rate,
  output logic               p_train,
  input  logic [WORD_W-1:0]  p_y,
  output logic               busy,
  output logic               done,
  output logic               converged,
  output logic [EPOCH_W-1:0] epoch_count,
  output logic [ADDR_W:0]    error_count
);

  localparam int WAIT_W = $clog2(PIPE_LAT + 1);

  train_state_t       state_q;
  logic [WAIT_W-1:0]  wait_q;
  logic [N-1:0]       p_x_q;
  logic [WORD_W-1:0]  p_exp_q;
  logic [WORD_W-1:0]  lr_q;
  logic               rd_en_q;
  logic               train_q;
  logic               done_q;
  logic               conv_q;

  logic               run_clr;
  logic               idx_inc;
  logic               err_inc;
  logic               epoch_end;
  logic [ADDR_W-1:0]  idx;
  logic               last_idx;
  logic               limit;
  logic               zero_err;
  logic               eval_last;
  logic               mismatch;

  assign eval_last = (wait_q == WAIT_W'(1));
  assign mismatch  = (p_y != p_exp_q);

  // Counter commands; abort suppresses all of them so the counts freeze.
  always_comb begin
    run_clr   = 1'b0;
    idx_inc   = 1'b0;
    err_inc   = 1'b0;
    epoch_end = 1'b0;
    if (!abort) begin
      case (state_q)
        S_IDLE:      run_clr   = start;
        S_EVAL:      err_inc   = eval_last && mismatch;
        S_NEXT:      idx_inc   = !last_idx;
        S_EPOCH_END: epoch_end = 1'b1;
        default: ;
      endcase
    end
  end

  train_epoch_counter #(
    .NUM_SAMPLES (NUM_SAMPLES),
    .ADDR_W      (ADDR_W),
    .MAX_EPOCHS  (MAX_EPOCHS),
    .EPOCH_W     (EPOCH_W)
  ) u_cnt (
    .clk         (clk),
    .rst_ni      (rst),
    .run_clr_i   (run_clr),
    .idx_inc_i   (idx_inc),
    .err_inc_i   (err_inc),
    .epoch_end_i (epoch_end),
    .idx_o       (idx),
    .epoch_o     (epoch_count),
    .err_o       (error_count),
    .last_idx_o  (last_idx),
    .limit_o     (limit),
    .zero_err_o  (zero_err)
  );

  // Strobes are registered on entry to their state, so each is high for exactly that state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      wait_q  <= '0;
      p_x_q   <= '0;
      p_exp_q <= '0;
      lr_q    <= '0;
      rd_en_q <= 1'b0;
      train_q <= 1'b0;
      done_q  <= 1'b0;
      conv_q  <= 1'b0;
    end else begin
      rd_en_q <= 1'b0;
      train_q <= 1'b0;
      done_q  <= 1'b0;
      if (abort && state_q != S_IDLE) begin
        state_q <= S_IDLE;
        conv_q  <= 1'b0;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (start && !abort) begin
              state_q <= S_FETCH;
              lr_q    <= learning_rate_in;
              conv_q  <= 1'b0;
              rd_en_q <= 1'b1;
            end
          end
          S_FETCH: state_q <= S_LOAD;
          S_LOAD: begin
            p_x_q   <= mem_x;
            p_exp_q <= mem_expected_y;
            wait_q  <= WAIT_W'(PIPE_LAT);
            state_q <= S_EVAL;
          end
          S_EVAL: begin
            wait_q <= wait_q - WAIT_W'(1);
            if (eval_last) begin
              if (mismatch) begin
                state_q <= S_UPDATE;
                train_q <= 1'b1;
              end else begin
                state_q <= S_NEXT;
              end
            end
          end
          S_UPDATE: state_q <= S_NEXT;
          S_NEXT: begin
            if (last_idx) begin
              state_q <= S_EPOCH_END;
            end else begin
              state_q <= S_FETCH;
              rd_en_q <= 1'b1;
            end
          end
          S_EPOCH_END: begin
            if (zero_err) begin
              conv_q  <= 1'b1;
              state_q <= S_DONE;
              done_q  <= 1'b1;
            end else if (limit) begin
              conv_q  <= 1'b0;
              state_q <= S_DONE;
              done_q  <= 1'b1;
            end else begin
              state_q <= S_FETCH;
              rd_en_q <= 1'b1;
            end
          end
          S_DONE: state_q <= S_IDLE;
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign mem_rd_en       = rd_en_q;
  assign mem_addr        = idx;
  assign p_x             = p_x_q;
  assign p_expected_y    = p_exp_q;
  assign p_learning_rate = lr_q;
  // An abort landing in UPDATE must cancel the strobe within the same cycle.
  assign p_train         = train_q && !abort;
  assign busy            = (state_q != S_IDLE);
  assign done            = done_q;
  assign converged       = conv_q;

endmodule

// File: tb/tb_perceptron_train_ctrl.sv
// Directed bench for perceptron_train_ctrl with a 4-sample memory and a perceptron stub.
module tb_perceptron_train_ctrl;

  localparam int N = 8;
  localparam int NS = 4;
  localparam int AW = 2;
  localparam int ME = 3;
  localparam int EW = 8;
  localparam int PL = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [31:0]   learning_rate_in = 32'h0;
  logic          mem_rd_en;
  logic [AW-1:0] mem_addr;
  logic [N-1:0]  mem_x = '0;
  logic [31:0]   mem_expected_y = '0;
  logic [N-1:0]  p_x;
  logic [31:0]   p_expected_y;
  logic [31:0]   p_learning_rate;
  logic          p_train;
  logic [31:0]   p_y = '0;
  logic          busy;
  logic          done;
  logic          converged;
  logic [EW-1:0] epoch_count;
  logic [AW:0]   error_count;

  perceptron_train_ctrl #(
    .N(N), .NUM_SAMPLES(NS), .ADDR_W(AW), .MAX_EPOCHS(ME), .EPOCH_W(EW), .PIPE_LAT(PL)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .learning_rate_in(learning_rate_in),
    .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_x(mem_x),
    .mem_expected_y(mem_expected_y),
    .p_x(p_x), .p_expected_y(p_expected_y), .p_learning_rate(p_learning_rate),
    .p_train(p_train), .p_y(p_y), .busy(busy), .done(done),
    .converged(converged), .epoch_count(epoch_count), .error_count(error_count)
  );

  always #5 clk = ~clk;

  // Low two bits of each sample vector equal its index, which the stub uses to identify it.
  logic [N-1:0] xs [NS] = '{8'hA4, 8'h5D, 8'hC6, 8'h3B};
  logic [31:0]  ys [NS] = '{32'h0001_2340, 32'h0005_6781, 32'h0009_ABC2, 32'h000D_EF03};

  always @(posedge clk) begin
    if (mem_rd_en) begin
      mem_x          <= xs[mem_addr];
      mem_expected_y <= ys[mem_addr];
    end
  end

  // Stub: mode 0 always right, mode 1 wrong on masked samples until trained once, mode 2 always wrong.
  int       mode = 0;
  logic [3:0] mask = 4'b0000;
  logic [3:0] learned = 4'b0000;
  logic       fail;
  always_comb begin
    fail = 1'b0;
    if (mode == 2) fail = 1'b1;
    else if (mode == 1) fail = mask[p_x[1:0]] && !learned[p_x[1:0]];
  end
  always @(posedge clk) begin
    p_y <= fail ? ~p_expected_y : p_expected_y;
    if (start && !busy) learned <= 4'b0000;
    else if (p_train) learned[p_x[1:0]] <= 1'b1;
  end

  int errors = 0;
  int checks = 0;
  logic [N-1:0] tr_x [16];
  int ncyc, ntrain, nrd;
  logic got_done;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; raises start, then watches until done or the cycle budget runs out.
  task automatic run(input int limit, input int restart_at, input logic [31:0] lr_mid);
    start = 1'b1;
    ncyc = 0; ntrain = 0; nrd = 0; got_done = 1'b0;
    for (int k = 1; k <= limit && !got_done; k++) begin
      @(posedge clk); #1;
      start = (k == restart_at);
      if (k == 3) learning_rate_in = lr_mid;
      @(negedge clk);
      if (p_train) begin
        if (ntrain < 16) tr_x[ntrain] = p_x;
        ntrain++;
      end
      if (mem_rd_en) nrd++;
      if (done) begin
        got_done = 1'b1;
        ncyc = k;
      end
    end
    start = 1'b0;
  endtask

  initial begin
    int seen;
    logic any_done;

    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_done", 32'(done), 32'h0);
    chk("rst_rd", 32'(mem_rd_en), 32'h0);
    chk("rst_px", 32'(p_x), 32'h0);
    chk("rst_lr", p_learning_rate, 32'h0);
    chk("rst_conv", 32'(converged), 32'h0);
    rst = 1'b1;
    @(negedge clk);

    // All samples match: one clean epoch.
    mode = 0;
    run(60, 0, 32'h0);
    chk("t1_done", 32'(got_done), 32'h1);
    chk("t1_cycle", 32'(ncyc), 32'd22);
    chk("t1_train", 32'(ntrain), 32'd0);
    chk("t1_reads", 32'(nrd), 32'd4);
    chk("t1_conv", 32'(converged), 32'h1);
    chk("t1_epoch", 32'(epoch_count), 32'd1);
    chk("t1_err", 32'(error_count), 32'd0);
    @(negedge clk);
    chk("t1_idle", 32'(busy), 32'h0);
    chk("t1_done_1cyc", 32'(done), 32'h0);

    // Samples 1 and 3 wrong in the first epoch only.
    mode = 1; mask = 4'b1010;
    run(100, 0, 32'h0);
    chk("t2_done", 32'(got_done), 32'h1);
    chk("t2_cycle", 32'(ncyc), 32'd45);
    chk("t2_train", 32'(ntrain), 32'd2);
    chk("t2_x0", 32'(tr_x[0]), 32'(xs[1]));
    chk("t2_x1", 32'(tr_x[1]), 32'(xs[3]));
    chk("t2_conv", 32'(converged), 32'h1);
    chk("t2_epoch", 32'(epoch_count), 32'd2);
    chk("t2_err", 32'(error_count), 32'd0);
    @(negedge clk);

    // Never converges: gives up at the epoch limit.
    mode = 2;
    run(150, 0, 32'h0);
    chk("t3_done", 32'(got_done), 32'h1);
    chk("t3_cycle", 32'(ncyc), 32'd76);
    chk("t3_train", 32'(ntrain), 32'd12);
    chk("t3_conv", 32'(converged), 32'h0);
    chk("t3_epoch", 32'(epoch_count), 32'd3);
    chk("t3_err", 32'(error_count), 32'd4);
    @(negedge clk);

    // Abort during the update of sample 2 in the first epoch.
    mode = 1; mask = 4'b0100;
    start = 1'b1;
    seen = 0;
    for (int k = 1; k <= 40 && seen == 0; k++) begin
      @(posedge clk); #1;
      start = 1'b0;
      @(negedge clk);
      if (p_train) seen = k;
    end
    chk("t4_upd_cycle", 32'(seen), 32'd15);
    abort = 1'b1;
    #1;
    chk("t4_train_kill", 32'(p_train), 32'h0);
    @(posedge clk); #1;
    abort = 1'b0;
    @(negedge clk);
    chk("t4_busy", 32'(busy), 32'h0);
    chk("t4_epoch", 32'(epoch_count), 32'd0);
    chk("t4_err", 32'(error_count), 32'd1);
    chk("t4_conv", 32'(converged), 32'h0);
    any_done = done;
    repeat (3) begin
      @(negedge clk);
      any_done = any_done | done;
    end
    chk("t4_no_done", 32'(any_done), 32'h0);

    // start and abort together in IDLE: stay idle.
    start = 1'b1; abort = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; abort = 1'b0;
    @(negedge clk);
    chk("t4_abort_wins", 32'(busy), 32'h0);

    // Extra start while busy has no effect.
    mode = 0;
    run(60, 5, 32'h0);
    chk("t5_done", 32'(got_done), 32'h1);
    chk("t5_cycle", 32'(ncyc), 32'd22);
    chk("t5_conv", 32'(converged), 32'h1);
    @(negedge clk);

    // Learning rate latched at start, unaffected by later changes.
    learning_rate_in = 32'h0000_8000;
    run(60, 0, 32'h0001_0000);
    chk("t6_done", 32'(got_done), 32'h1);
    chk("t6_lr_hold", p_learning_rate, 32'h0000_8000);
    @(negedge clk);
    chk("t6_lr_idle", p_learning_rate, 32'h0000_8000);

    // Reset asserted mid-EVAL clears outputs without a clock edge.
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("t6_lr_new", p_learning_rate, 32'h0001_0000);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    chk("t5_px_loaded", 32'(p_x), 32'(xs[0]));
    #2;
    rst = 1'b0;
    #1;
    chk("t5_rst_busy", 32'(busy), 32'h0);
    chk("t5_rst_px", 32'(p_x), 32'h0);
    chk("t5_rst_py", p_expected_y, 32'h0);
    chk("t5_rst_lr", p_learning_rate, 32'h0);
    chk("t5_rst_epoch", 32'(epoch_count), 32'h0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    run(60, 0, 32'h0001_0000);
    chk("t5_fresh_cycle", 32'(ncyc), 32'd22);
    chk("t5_fresh_conv", 32'(converged), 32'h1);
    chk("t5_fresh_epoch", 32'(epoch_count), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/perceptron_train_ctrl.md
Name: perceptron_train_ctrl

Overview:
Training sequencer for the single-layer perceptron. Streams a stored sample set (input vector plus expected output) from a synchronous sample memory into the perceptron, one sample at a time. Compares the perceptron output against the expected value and pulses the perceptron's train input on each mismatch. Repeats full epochs until an epoch completes with zero errors (converged) or a maximum epoch count is reached.

Parameters:
N, 8, perceptron input vector width in bits
NUM_SAMPLES, 16, samples per epoch (≥2)
ADDR_W, 4, sample memory address width; 2**ADDR_W ≥ NUM_SAMPLES
MAX_EPOCHS, 255, epoch limit before giving up
EPOCH_W, 8, epoch counter width; must hold MAX_EPOCHS
PIPE_LAT, 2, cycles from p_x/p_expected_y change to p_y valid (≥1)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-low reset
start  in  1  begin a training run; sampled only in IDLE
abort  in  1  terminate run, return to IDLE
learning_rate_in  in  32  fixed-point learning rate, latched on accepted start
mem_rd_en  out  1  sample memory read strobe
mem_addr  out  ADDR_W  sample index
mem_x  in  N  sample input vector, valid the cycle after mem_rd_en
mem_expected_y  in  32  sample expected output, same timing as mem_x
p_x  out  N  perceptron input vector
p_expected_y  out  32  perceptron expected output
p_learning_rate  out  32  latched learning rate
p_train  out  1  one-cycle weight-update strobe
p_y  in  32  perceptron output
busy  out  1  high outside IDLE
done  out  1  one-cycle pulse at run completion
converged  out  1  result of last completed run; held until next accepted start
epoch_count  out  EPOCH_W  completed epochs in current/last run
error_count  out  ADDR_W+1  mismatches in current/last epoch

Behaviour:
- Reset (rst=0, async): state=IDLE; all outputs 0; index, wait counter and latched data registers cleared.
- States: IDLE, FETCH, LOAD, EVAL, UPDATE, NEXT, EPOCH_END, DONE.
- IDLE: on start=1, go to FETCH next cycle. Latch learning_rate_in. Clear index, epoch_count, error_count and converged.
- FETCH: mem_rd_en=1 and mem_addr=index for exactly this cycle. Next state LOAD.
- LOAD: register mem_x into p_x and mem_expected_y into p_expected_y; load wait counter with PIPE_LAT. Next state EVAL.
  - p_x and p_expected_y hold their values until the next LOAD, including through IDLE.
- EVAL: decrement wait counter each cycle. In the cycle the counter reaches 0, compare the full 32 bits of p_y against p_expected_y.
  - Unequal: go to UPDATE.
  - Equal: go to NEXT.
  - EVAL therefore lasts PIPE_LAT cycles.
- UPDATE: p_train=1 for exactly this cycle; error_count+1. Next state NEXT.
- NEXT: if index==NUM_SAMPLES-1, go to EPOCH_END; else index+1 and go to FETCH.
- Per-sample latency: 3+PIPE_LAT cycles on match, 4+PIPE_LAT on mismatch.
- EPOCH_END: epoch_count+1.
  - If error_count==0: converged=1, go to DONE.
  - Else if the new epoch_count==MAX_EPOCHS: converged=0, go to DONE.
  - Else: index=0, error_count=0, go to FETCH.
- error_count keeps the final epoch's value after DONE.
- DONE: done=1 for one cycle. Next state IDLE.
- abort: highest priority, any non-IDLE state → IDLE next cycle.
  - p_train forced 0 in that cycle, even if UPDATE would have fired.
  - No done pulse; converged=0.
  - epoch_count and error_count frozen at their current values.
- start while busy: ignored. start and abort both high in IDLE: abort wins, remain IDLE.
- p_train never asserts outside UPDATE. mem_rd_en never asserts outside FETCH.

Decomposition:
- Shared package perceptron_pkg:
  - WORD_W=32, the fixed-point word width shared with the perceptron datapath.
  - State enum train_state_t.
- One natural sub-module, train_epoch_counter: index, epoch and error counters, plus the end-of-epoch, limit and zero-error flags.
- The FSM stays in the top.

Test Plan:
All tests use NUM_SAMPLES=4, PIPE_LAT=2, MAX_EPOCHS=3, and a behavioural perceptron stub with 2-cycle latency.
1. Stub returns p_y==p_expected_y always; start at cycle 0 → FETCH at cycle 1. p_train never high. done pulses at cycle 22 with converged=1, epoch_count=1, error_count=0.
2. Stub mismatches samples 1 and 3 in epoch 1 only → two single-cycle p_train pulses, each with p_x matching mem_x of that sample. done with converged=1, epoch_count=2, error_count=0.
3. Stub always mismatches → 12 p_train pulses in total. done with converged=0, epoch_count=3, error_count=4.
4. abort in UPDATE of sample 2, epoch 1 → no p_train that cycle, busy=0 next cycle, no done pulse. epoch_count=0, error_count=1.
5. start pulsed while busy; then rst=0 asserted mid-EVAL.
   - Extra start: no effect on the run.
   - Reset: all outputs 0 immediately, with no clock edge required.
   - After reset release, a fresh start behaves as in test 1.
6. learning_rate_in=0x0000_8000 at start, then changed to 0x0001_0000 mid-run → p_learning_rate stays 0x0000_8000 until the next accepted start.
